// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
package uart_pkg;

  localparam int UART_DATA_W    = 8;
  localparam bit UART_PARITY_EN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit buffer. Ready is registered and only reflects occupancy,
// so a full buffer never accepts a byte even when a pop happens that cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ready;
  logic [CW-1:0] w_count_nxt;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_ready = r_ready;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes are framed as start bit, 8 data bits LSB
// first, optional even parity bit and one stop bit, back-to-back when queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = UART_PARITY_EN,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [UART_DATA_W-1:0]         tx_data,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic                           tx,
  output logic                           tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output uart_tx_state_t                 o_dbg_state
);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_W - 1);

  uart_tx_state_t         r_state, w_state_nxt;
  logic [15:0]            r_cnt, w_cnt_nxt;
  logic [2:0]             r_bit_idx, w_bit_idx_nxt;
  logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
  logic                   r_parity, w_parity_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   w_pop;
  logic                   w_bit_done;
  logic                   w_fifo_nempty;
  logic [UART_DATA_W-1:0] w_fifo_dout;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (tx_valid),
    .i_din   (tx_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (fifo_count),
    .o_ready (tx_ready)
  );

  assign w_fifo_nempty = (fifo_count != '0);
  assign w_bit_done    = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 16'd1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_pop         = 1'b0;
    w_tx_nxt      = 1'b1;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_done) begin
          w_state_nxt   = DATA;
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
        end
      end
      DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        w_tx_nxt = r_parity;
        if (w_bit_done) begin
          w_state_nxt = STOP;
          w_cnt_nxt   = '0;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_cnt_nxt = '0;
          if (w_fifo_nempty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Parity is taken from the popped byte, before shifting destroys it.
    if (w_pop) begin
      w_shift_nxt  = w_fifo_dout;
      w_parity_nxt = even_parity(w_fifo_dout);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  assign tx          = r_tx;
  assign tx_busy     = (r_state != IDLE) | w_fifo_nempty;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (no parity / even parity) at 4 clocks per bit,
// serial lines decoded cycle by cycle and compared with frames built from a byte queue.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic [7:0] data0, data1;
  logic valid0, valid1;
  logic [1:0] tx_w, ready_w, busy_w;
  logic [2:0] cnt0, cnt1;
  uart_tx_state_t st0, st1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int last_end[2];
  int last_gap[2];
  int frames[2];

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]),
    .fifo_count(cnt0), .o_dbg_state(st0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]),
    .fifo_count(cnt1), .o_dbg_state(st1)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: bit 0 is the first bit on the line; unused top bits stay 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input int par);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    if (par != 0) f[9] = (($countones(b) % 2) == 1);
    return f;
  endfunction

  // Serial decoder: samples every cycle of a frame, each bit cell must be constant.
  task automatic monitor(input int d);
    int nb;
    logic [10:0] obs;
    logic stable;
    logic abort;
    logic [7:0] eb;
    nb = 10 + d;
    forever begin
      @(posedge clk); #1;
      if (reset && tx_w[d] === 1'b0) begin
        obs = '1;
        stable = 1'b1;
        abort = 1'b0;
        last_gap[d] = cyc - last_end[d];
        for (int b = 0; b < nb && !abort; b++) begin
          for (int c = 0; c < CPB && !abort; c++) begin
            if (b != 0 || c != 0) begin
              @(posedge clk); #1;
            end
            if (!reset) abort = 1'b1;
            else if (c == 0) obs[b] = tx_w[d];
            else if (tx_w[d] !== obs[b]) stable = 1'b0;
          end
        end
        if (!abort) begin
          last_end[d] = cyc + 1;
          frames[d]++;
          if (d == 0 && exp_q0.size() == 0) begin
            check("dut0_unexpected_frame", exp_q0.size(), 1);
          end else if (d == 1 && exp_q1.size() == 0) begin
            check("dut1_unexpected_frame", exp_q1.size(), 1);
          end else begin
            eb = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("dut%0d_frame_%02h", d, eb), obs, frame_bits(eb, d));
            check($sformatf("dut%0d_bitwidth_%02h", d, eb), stable, 1);
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // ---------------- drivers ----------------
  task automatic send(input int d, input logic [7:0] b);
    int n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    if (d == 0) begin data0 = b; valid0 = 1'b1; end
    else        begin data1 = b; valid1 = 1'b1; end
    forever begin
      rdy = ready_w[d];
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 2000) begin
        check($sformatf("dut%0d_send_timeout", d), rdy, 1);
        break;
      end
    end
    if (d == 0) begin valid0 = 1'b0; data0 = 8'($urandom); end
    else        begin valid1 = 1'b0; data1 = 8'($urandom); end
    if (rdy) begin
      if (d == 0) exp_q0.push_back(b);
      else        exp_q1.push_back(b);
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (busy_w[d] !== 1'b0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("dut%0d_idle_in_time", d), (n < 5000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int f;
    valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    last_end = '{0, 0}; last_gap = '{0, 0}; frames = '{0, 0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx0", tx_w[0], 1);
    check("rst_ready0", ready_w[0], 0);
    check("rst_busy0", busy_w[0], 0);
    check("rst_count0", cnt0, 0);
    check("rst_state0", st0, IDLE);
    check("rst_tx1", tx_w[1], 1);
    check("rst_ready1", ready_w[1], 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release0", ready_w[0], 1);
    check("ready_after_release1", ready_w[1], 1);

    // 0x55 without parity, with start-bit latency from the accepting edge
    send(0, 8'h55);
    check("lat_k0_tx", tx_w[0], 1);
    check("lat_k0_busy", busy_w[0], 1);
    @(posedge clk); #1;
    check("lat_k1_tx", tx_w[0], 1);
    @(posedge clk); #1;
    check("lat_k2_tx", tx_w[0], 0);
    wait_idle(0);
    check("after55_tx", tx_w[0], 1);
    check("after55_frames", frames[0], 1);

    // 0x07 with even parity
    send(1, 8'h07);
    wait_idle(1);
    check("after07_frames", frames[1], 1);

    // six offers back-to-back into a 4-deep buffer
    for (int i = 0; i < 6; i++) begin
      data0 = 8'hC0 + 8'(i);
      valid0 = 1'b1;
      check($sformatf("b2b_ready_%0d", i), ready_w[0], (i < 5));
      if (i < 5) exp_q0.push_back(8'hC0 + 8'(i));
      @(posedge clk); #1;
    end
    valid0 = 1'b0;
    check("b2b_count_full", cnt0, 4);
    check("b2b_ready_full", ready_w[0], 0);
    wait_idle(0);
    check("b2b_frames", frames[0], 6);

    // two buffered bytes must run with no idle gap
    send(0, 8'hA1);
    send(0, 8'h3C);
    wait_idle(0);
    check("gap_a1_3c", last_gap[0], 0);

    // loopback-style byte stream
    send(0, 8'h00);
    send(0, 8'hFF);
    send(0, 8'h5A);
    wait_idle(0);

    // randomized traffic on both instances
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(int'($urandom_range(0, 1)), 8'($urandom));
    end
    wait_idle(0);
    wait_idle(1);

    // reset in the middle of a 0x00 frame with another byte buffered
    send(0, 8'h00);
    send(0, 8'h11);
    n = 0;
    while (tx_w[0] !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_frame_started", tx_w[0], 0);
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_tx", tx_w[0], 1);
    check("midrst_count", cnt0, 0);
    check("midrst_ready", ready_w[0], 0);
    check("midrst_busy", busy_w[0], 0);
    exp_q0.delete();
    exp_q1.delete();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_tx_held", tx_w[0], 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_ready_release", ready_w[0], 1);
    f = frames[0];
    send(0, 8'hFF);
    wait_idle(0);
    check("postrst_frames", frames[0], f + 1);

    check("leftover_q0", exp_q0.size(), 0);
    check("leftover_q1", exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit after the data bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; power of two, 2..16.
REQ-004 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port tx_data, input, 8, byte to send.
REQ-007 SHALL have port tx_valid, input, 1, byte offered.
REQ-008 SHALL have port tx_ready, output, 1, buffer can accept a byte.
REQ-009 SHALL have port tx, output, 1, serial line, idle high.
REQ-010 SHALL have port tx_busy, output, 1, frame in progress or buffer non-empty.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, bytes buffered, excluding the byte in flight.

Function
REQ-012 SHALL accept a byte on a rising edge where tx_valid & tx_ready; tx_valid while tx_ready=0 is ignored, with no state change.
REQ-013 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH), registered; there is no full-FIFO bypass, even when a pop happens in the same cycle.
REQ-014 SHALL apply push and pop in the same cycle together, leaving fifo_count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: tx=1; when the FIFO is non-empty, pop the head into a shift register, go to START.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-018 DATA: tx = shift[0], LSB first, each bit held CLKS_PER_BIT cycles; after bit 7 go to PARITY if PARITY_EN, else STOP.
REQ-019 PARITY: tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles; then, if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
REQ-021 SHALL register tx, with no combinational path from any input to tx.
REQ-022 Latency: a byte accepted at edge k into an empty FIFO while IDLE SHALL drive tx low from edge k+2.
REQ-023 SHALL use a bit-period counter of 0..CLKS_PER_BIT-1 that reloads 0 on every state or bit change; the frame is exactly (10 + PARITY_EN) * CLKS_PER_BIT cycles.
REQ-024 SHALL drive tx_busy = (state != IDLE) | (fifo_count != 0).
REQ-025 SHALL ignore changes to tx_data after acceptance; the transmitted byte is the value captured at acceptance.

Reset
REQ-026 While reset=0, outputs SHALL be immediately: tx=1, tx_ready=0, tx_busy=0, fifo_count=0; state=IDLE, counters and pointers cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame, drive tx=1 immediately and discard buffered bytes.
REQ-028 tx_ready SHALL go to 1 on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place the FSM state enum (uart_tx_state_t) and the parity-enable and data-width constants in a shared package uart_pkg, which the receiver also uses.
REQ-030 SHALL implement the buffer as sub-module uart_tx_fifo (sync FIFO with push, pop, dout, count); the FSM and the bit counter stay in uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-031 Send 0x55, PARITY_EN=0 -> tx = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, then idle high; tx_busy falls after the stop bit.
REQ-032 Send 0x07, PARITY_EN=1 -> bits 0,1,1,1,0,0,0,0,0,1(parity),1, 44 cycles.
REQ-033 Push 6 bytes back-to-back, FIFO_DEPTH=4 -> 5 accepted (1 in flight, 4 buffered), tx_ready=0 on the 6th; the 6th byte is never sent.
REQ-034 Bytes 0xA1 then 0x3C buffered -> the 0x3C start bit begins on the cycle after the 0xA1 stop bit ends, with no idle gap.
REQ-035 Assert reset at cycle 13 of a 0x00 frame -> tx=1 in the same cycle, fifo_count=0; after release, a new byte 0xFF transmits correctly.
REQ-036 Loopback of tx to the existing UART receiver, bytes 0x00, 0xFF, 0x5A -> the receiver's rx_data matches each byte, in order.
